// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the bit-serial add/subtract engine.
//   state_t  FSM state encoding (IDLE, RUN, DONE)
//   OP_ADD / OP_SUB  operation select values for the op input
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_cell.sv
// addsub_cell: combinational one-bit full-adder / full-subtractor.
//   a, b  operand bits
//   cin   incoming carry (add) or borrow (sub)
//   op    OP_ADD or OP_SUB
//   s     sum or difference bit
//   cout  outgoing carry (add) or borrow (sub)
module addsub_cell
  import addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic op,
  output logic s,
  output logic cout
);

  logic x;

  assign x = a ^ b;
  assign s = x ^ cin;

  // Borrow propagates when the bits are equal; carry propagates when they differ.
  always_comb begin
    if (op == OP_SUB) cout = (~a & b) | (cin & ~x);
    else              cout = (a & b) | (cin & x);
  end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract engine, one bit per clock, LSB first.
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   request, sampled only in IDLE
//   op      0 = add, 1 = subtract, sampled with start
//   a, b    WIDTH-bit operands, sampled with start
//   busy    high in RUN and DONE
//   done    one-cycle pulse, result/flag valid
//   result  sum or difference modulo 2^WIDTH, held until next completion
//   flag    carry-out (add) or borrow-out (sub), held with result
//
// state | meaning
// IDLE  | waiting for start; outputs hold last completed result
// RUN   | one operand bit processed per edge, LSB first
// DONE  | single cycle with done=1, then back to IDLE
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             op_r;
  logic             bit_s;
  logic             bit_c;

  addsub_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .op   (op_r),
    .s    (bit_s),
    .cout (bit_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      op_r   <= OP_ADD;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            op_r  <= op;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          acc   <= WIDTH'({bit_s, acc} >> 1);
          carry <= bit_c;
          cnt   <= cnt + 1'b1;
          // Result is only published here, so partial sums never reach the port.
          if (cnt == LAST) begin
            result <= WIDTH'({bit_s, acc} >> 1);
            flag   <= bit_c;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
